// File: rtl/ber_checker.sv
// PRBS bit-error-rate checker: searches for the rx/ref alignment delay, then counts bits and errors.
// Optional lock-loss/re-search in TRACK is enabled by defining BER_RELOCK_EN.
module ber_checker #(
  parameter int DELAY_W   = 9,
  parameter int ALIGN_LEN = 511,
  parameter int CNT_W     = 64,
  parameter int LOSS_THR  = 128
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic               i_ref_bit,
  input  logic               i_rx_bit,
  output logic               o_locked,
  output logic [DELAY_W-1:0] o_delay,
  output logic [CNT_W-1:0]   o_error_count,
  output logic [CNT_W-1:0]   o_bit_count
);

  localparam int DEPTH = 2 ** DELAY_W;
  // The window error counter must also hold the loss threshold so the compare never truncates.
  localparam int WIN_MAX = (ALIGN_LEN > LOSS_THR) ? ALIGN_LEN : LOSS_THR;
  localparam int WIN_W   = $clog2(WIN_MAX + 1);

  localparam logic [0:0] S_SEARCH = 1'b0;
  localparam logic [0:0] S_TRACK  = 1'b1;

  localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(ALIGN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [0:0]         state;
  logic [DEPTH-1:0]   history;
  logic [DELAY_W-1:0] wr_ptr;
  logic [DELAY_W-1:0] rd_ptr;
  logic [WIN_W-1:0]   win_cnt;
  logic [WIN_W-1:0]   win_err;
  logic [WIN_W-1:0]   win_err_next;
  logic               ref_sel;
  logic               mismatch;
  logic               win_last;

  // d=0 has no history entry yet (it is written on this same edge), so use the live ref bit.
  assign rd_ptr       = wr_ptr - o_delay;
  assign ref_sel      = (o_delay == '0) ? i_ref_bit : history[rd_ptr];
  assign mismatch     = i_rx_bit ^ ref_sel;
  assign win_last     = (win_cnt == WIN_LAST);
  assign win_err_next = win_err + WIN_W'(mismatch);
  assign o_locked     = (state == S_TRACK);

  // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clock) begin
    if (i_reset) begin
      state         <= S_SEARCH;
      o_delay       <= '0;
      o_error_count <= '0;
      o_bit_count   <= '0;
      win_cnt       <= '0;
      win_err       <= '0;
      wr_ptr        <= '0;
      // NOTE: the history is reset on purpose: unwritten entries must compare as 0.
      history       <= '0;
    end else if (i_enable) begin
      history[wr_ptr] <= i_ref_bit;
      wr_ptr          <= wr_ptr + DELAY_W'(1);

      if (state == S_SEARCH) begin
        if (win_last) begin
          win_cnt <= '0;
          win_err <= '0;
          if (win_err_next == '0) begin
            state <= S_TRACK;
          end else begin
            o_delay <= o_delay + DELAY_W'(1);
          end
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          win_err <= win_err_next;
        end
      end else begin
        if (o_bit_count != CNT_MAX) begin
          o_bit_count <= o_bit_count + CNT_W'(1);
        end
        if (mismatch && (o_error_count != CNT_MAX)) begin
          o_error_count <= o_error_count + CNT_W'(1);
        end
`ifdef BER_RELOCK_EN
        // Too many errors in one window means the channel delay moved: resume searching at d+1.
        if (win_last) begin
          win_cnt <= '0;
          win_err <= '0;
          if (win_err_next > WIN_W'(LOSS_THR)) begin
            state   <= S_SEARCH;
            o_delay <= o_delay + DELAY_W'(1);
          end
        end else begin
          win_cnt <= win_cnt + WIN_W'(1);
          win_err <= win_err_next;
        end
`endif
      end
    end
  end

endmodule
